data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory responder for the control unit: serialises word loads/stores onto an
// internal synchronous array, holding the pipeline with stall for LATENCY cycles.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        stall
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q, bad_q;
  logic [31:0]   rdata_q;

  logic          req, in_bad, accept, complete;
  logic [IW-1:0] in_idx, acc_idx;
  logic [31:0]   acc_wdata;
  logic          acc_wr, acc_bad;

  logic [31:0]   mem [DEPTH];

  assign req    = mem_read | mem_write;
  assign in_idx = addr[IW+1:2];
  assign in_bad = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
                  (addr[31:2] >= 30'(DEPTH));

  // With LATENCY=1 the access completes on the accept edge, so it must use the
  // live inputs rather than the captured copies.
  assign acc_idx   = (state_q == IDLE) ? in_idx : idx_q;
  assign acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? mem_write : wr_q;
  assign acc_bad   = (state_q == IDLE) ? in_bad : bad_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall  = 1'b1;
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d  = DONE;
            complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d  = DONE;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stall    = 1'b0;
      accept   = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= in_idx;
        wdata_q <= wdata;
        wr_q    <= mem_write;
        bad_q   <= in_bad;
      end
      if (complete) begin
        if (acc_bad)     rdata_q <= '0;
        else if (!acc_wr) rdata_q <= mem[acc_idx];
      end
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && complete && !acc_bad && acc_wr) mem[acc_idx] <= acc_wdata;
  end

  assign rdata       = rst ? '0 : rdata_q;
  assign rdata_valid = !rst && (state_q == DONE) && !bad_q && !wr_q;
  assign err         = !rst && (state_q == DONE) && bad_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (LATENCY 1, 2, 4) driven
// independently and checked against a word-array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_a   [3];
  logic        rd_a    [3];
  logic        wr_a    [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rdata_a [3];
  logic        valid_a [3];
  logic        err_a   [3];
  logic        stall_a [3];

  int          checks = 0;
  int          errors = 0;
  int          lat    [3] = '{1, 2, 4};
  logic [31:0] mm     [3][256];
  logic [31:0] exp_rd [3];

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_a[0]), .mem_read(rd_a[0]), .mem_write(wr_a[0]),
    .addr(addr_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0]),
    .rdata_valid(valid_a[0]), .err(err_a[0]), .stall(stall_a[0]));

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst_a[1]), .mem_read(rd_a[1]), .mem_write(wr_a[1]),
    .addr(addr_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1]),
    .rdata_valid(valid_a[1]), .err(err_a[1]), .stall(stall_a[1]));

  data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst_a[2]), .mem_read(rd_a[2]), .mem_write(wr_a[2]),
    .addr(addr_a[2]), .wdata(wdata_a[2]), .rdata(rdata_a[2]),
    .rdata_valid(valid_a[2]), .err(err_a[2]), .stall(stall_a[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int k);
    chk({tag, "_stall"}, k, 32'(stall_a[k]), 32'd0);
    chk({tag, "_valid"}, k, 32'(valid_a[k]), 32'd0);
    chk({tag, "_err"},   k, 32'(err_a[k]),   32'd0);
    chk({tag, "_rdata"}, k, rdata_a[k], exp_rd[k]);
  endtask

  // One full transaction; inputs stay visible through the DONE-exit edge so a
  // re-accept from DONE would show up as stall or a second pulse.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    int   w;
    logic bad;
    bad = (rd && wr) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    @(negedge clk);
    rd_a[k] = rd; wr_a[k] = wr; addr_a[k] = a; wdata_a[k] = d;
    #1;
    w = 0;
    while (stall_a[k] === 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
      #1;
    end
    chk("stall_width", k, 32'(w), 32'(lat[k]));
    if (bad)     exp_rd[k] = '0;
    else if (wr) mm[k][a[9:2]] = d;
    else         exp_rd[k] = mm[k][a[9:2]];
    chk("done_err",   k, 32'(err_a[k]),   32'(bad));
    chk("done_valid", k, 32'(valid_a[k]), 32'(!bad && rd));
    chk("done_rdata", k, rdata_a[k], exp_rd[k]);
    @(posedge clk);
    #1;
    rd_a[k] = 1'b0; wr_a[k] = 1'b0;
    #1;
    quiet("after_done", k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          t;
    clk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b1; rd_a[k] = 1'b0; wr_a[k] = 1'b0;
      addr_a[k] = '0; wdata_a[k] = '0; exp_rd[k] = '0;
    end

    // Reset held for two cycles with no request.
    #1;
    for (int k = 0; k < 3; k++) quiet("reset", k);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) quiet("reset", k);
    end
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) quiet("post_reset", k);

    // Preload a known working set: words 0..15 and the last word.
    for (int k = 0; k < 3; k++) begin
      for (int unsigned w = 0; w < 17; w++) begin
        a = (w == 16) ? 32'h3FC : 32'(w << 2);
        access(k, 1'b0, 1'b1, a, $urandom);
      end
    end

    for (int k = 0; k < 3; k++) begin
      access(k, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      access(k, 1'b1, 1'b0, 32'h10, 32'h0);
      access(k, 1'b1, 1'b0, 32'h0,  32'h0);
      access(k, 1'b0, 1'b1, 32'h3FC, $urandom);
      access(k, 1'b1, 1'b0, 32'h3FC, 32'h0);
      access(k, 1'b1, 1'b0, 32'h0,  32'h0);
      // Rejected requests, then confirm the array is untouched.
      access(k, 1'b1, 1'b0, 32'h12,  32'h0);
      access(k, 1'b0, 1'b1, 32'h400, $urandom);
      access(k, 1'b1, 1'b1, 32'h10,  $urandom);
      access(k, 1'b1, 1'b0, 32'h10,  32'h0);
      access(k, 1'b1, 1'b0, 32'h0,   32'h0);
    end

    // Reset in the second cycle of a write drops the write.
    access(1, 1'b0, 1'b1, 32'h20, 32'h0000AAAA);
    @(negedge clk);
    wr_a[1] = 1'b1; addr_a[1] = 32'h20; wdata_a[1] = 32'h00001234;
    #1;
    chk("midrst_accept_stall", 1, 32'(stall_a[1]), 32'd1);
    @(negedge clk);
    rst_a[1] = 1'b1; wr_a[1] = 1'b0;
    exp_rd[1] = '0;
    #1;
    quiet("midrst_during", 1);
    @(negedge clk);
    rst_a[1] = 1'b0;
    #1;
    quiet("midrst_after", 1);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0);

    // No request for ten cycles with random address/data.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        addr_a[k] = $urandom; wdata_a[k] = $urandom;
      end
      #1;
      for (int k = 0; k < 3; k++) quiet("idle", k);
    end
    for (int k = 0; k < 3; k++) begin
      access(k, 1'b1, 1'b0, 32'h3FC, 32'h0);
      access(k, 1'b1, 1'b0, 32'h10,  32'h0);
    end

    // Randomized mix of loads, stores and rejected requests.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 30; n++) begin
        t = int'($urandom_range(0, 9));
        a = ($urandom_range(0, 16) == 16) ? 32'h3FC : 32'($urandom_range(0, 15) << 2);
        d = $urandom;
        case (t)
          0:       access(k, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), d);
          1:       access(k, 1'b0, 1'b1, 32'h400 + 32'($urandom_range(0, 255) << 2), d);
          2:       access(k, 1'b1, 1'b1, a, d);
          3, 4, 5, 6: access(k, 1'b1, 1'b0, a, d);
          default: access(k, 1'b0, 1'b1, a, d);
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
